mem_port_arbiter: RTL and testbench

- Sequences every access to the single-port synchronous main RAM and shares it between two requesters.
- Requester 1 is the CPU datapath: MAR address, MDR write data, read/write strobes from the control unit.
- Requester 2 is the debug/program-loader port.
- Provides per-requester request/acknowledge handshakes, configurable wait states and a CPU stall indication.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / debug) sequencer for a single-port synchronous RAM.
// Optional MEM_ARB_ROUND_ROBIN_EN: ties alternate away from the last owner.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_done_o,
  output logic              cpu_wait_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic OwnCpu = 1'b0;
  localparam logic OwnDbg = 1'b1;
  localparam logic [3:0] WaitLoad = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mask_cpu_q, mask_cpu_d;
  logic              mask_dbg_q, mask_dbg_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic cpu_pend, dbg_pend, grant_dbg;

  // The requester just served is ignored for one IDLE cycle so its held level
  // is not mistaken for a new transaction.
  assign cpu_pend = (cpu_read_i | cpu_write_i) & ~mask_cpu_q;
  assign dbg_pend = dbg_req_i & ~mask_dbg_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
  assign grant_dbg = dbg_pend & (~cpu_pend | (last_owner_q == OwnCpu));
`else
  assign grant_dbg = dbg_pend & ~cpu_pend;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    mask_cpu_d  = 1'b0;
    mask_dbg_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cpu_pend || dbg_pend) begin
          owner_d = grant_dbg ? OwnDbg : OwnCpu;
          if (grant_dbg) begin
            we_d    = dbg_we_i;
            addr_d  = dbg_addr_i;
            wdata_d = dbg_wdata_i;
          end else begin
            // read+write together resolves to a write
            we_d    = cpu_write_i;
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
          end
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (WAIT_STATES == 0) begin
          state_d = StDone;
        end else begin
          cnt_d   = WaitLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (!we_q) begin
          if (owner_q == OwnDbg) begin
            dbg_rdata_d = mem_rdata_i;
          end else begin
            cpu_rdata_d = mem_rdata_i;
          end
        end
        mask_cpu_d = (owner_q == OwnCpu);
        mask_dbg_d = (owner_q == OwnDbg);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_d = owner_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 4'd0;
      mask_cpu_q  <= 1'b0;
      mask_dbg_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= OwnDbg;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      mask_cpu_q  <= mask_cpu_d;
      mask_dbg_q  <= mask_dbg_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign mem_en_o    = (state_q == StAccess);
  assign mem_we_o    = mem_en_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_done_o  = (state_q == StDone) & (owner_q == OwnCpu);
  assign dbg_ack_o   = (state_q == StDone) & (owner_q == OwnDbg);
  assign cpu_wait_o  = (cpu_read_i | cpu_write_i) & ~cpu_done_o;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions, completion order and
// read data checked by a monitor; a second WAIT_STATES=0 instance checks back-to-back timing.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write, dbg_req, dbg_we;
  logic [8:0]  cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_wait, dbg_ack, mem_en, mem_we;

  logic        c0_read, c0_zero;
  logic [8:0]  c0_addr, c0_mem_addr;
  logic [31:0] c0_zdata, c0_rdata, c0_dbg_rdata, c0_mem_wdata, c0_mem_rdata;
  logic        c0_done, c0_wait, c0_ack, c0_mem_en, c0_mem_we;

  logic [31:0] ram [512];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {logic dbg; logic [31:0] data;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(1)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_read_i(cpu_read), .cpu_write_i(cpu_write), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_done_o(cpu_done),
    .cpu_wait_o(cpu_wait), .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .reset_i(reset),
    .cpu_read_i(c0_read), .cpu_write_i(c0_zero), .cpu_addr_i(c0_addr),
    .cpu_wdata_i(c0_zdata), .cpu_rdata_o(c0_rdata), .cpu_done_o(c0_done),
    .cpu_wait_o(c0_wait), .dbg_req_i(c0_zero), .dbg_we_i(c0_zero), .dbg_addr_i(c0_addr),
    .dbg_wdata_i(c0_zdata), .dbg_rdata_o(c0_dbg_rdata), .dbg_ack_o(c0_ack),
    .mem_en_o(c0_mem_en), .mem_we_o(c0_mem_we), .mem_addr_o(c0_mem_addr),
    .mem_wdata_o(c0_mem_wdata), .mem_rdata_i(c0_mem_rdata)
  );

  // Synchronous RAM models: read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
    if (c0_mem_en) c0_mem_rdata <= 32'hC0DE_0000 | {23'd0, c0_mem_addr};
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic expect_item(input logic dbg, input logic [31:0] data);
    exp_t e;
    e.dbg  = dbg;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: pop on every completion pulse, check owner, then rdata one cycle later.
  initial begin : monitor
    exp_t e;
    logic pend_cpu, pend_dbg;
    logic [31:0] pend_data;
    pend_cpu = 1'b0;
    pend_dbg = 1'b0;
    pend_data = '0;
    forever begin
      @(negedge clk);
      if (pend_cpu) check("cpu_rdata", cpu_rdata, pend_data);
      if (pend_dbg) check("dbg_rdata", dbg_rdata, pend_data);
      pend_cpu = 1'b0;
      pend_dbg = 1'b0;
      if (cpu_done || dbg_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", {30'd0, dbg_ack, cpu_done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("completion_owner", {31'd0, dbg_ack}, {31'd0, e.dbg});
          pend_cpu  = cpu_done;
          pend_dbg  = dbg_ack;
          pend_data = e.data;
        end
      end
    end
  end

  task automatic cpu_txn(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] d, input int lat);
    int cyc;
    logic got;
    @(posedge clk); #1;
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (cyc == 0) check("cpu_wait_pending", {31'd0, cpu_wait}, 32'd1);
      if (cyc == lat - 2) begin
        check("cpu_access_en", {31'd0, mem_en}, 32'd1);
        check("cpu_access_we", {31'd0, mem_we}, {31'd0, wr});
        check("cpu_access_addr", {23'd0, mem_addr}, {23'd0, a});
        if (wr) check("cpu_access_wdata", mem_wdata, d);
      end
      if (cpu_done) begin
        got = 1'b1;
        check("cpu_wait_at_done", {31'd0, cpu_wait}, 32'd0);
      end else begin
        cyc++;
      end
    end
    check("cpu_latency", cyc, lat);
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic dbg_txn(input logic we, input logic [8:0] a, input logic [31:0] d,
                         input int lat);
    int cyc;
    logic got;
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (cyc == lat - 2) begin
        check("dbg_access_en", {31'd0, mem_en}, 32'd1);
        check("dbg_access_we", {31'd0, mem_we}, {31'd0, we});
        check("dbg_access_addr", {23'd0, mem_addr}, {23'd0, a});
      end
      if (dbg_ack) got = 1'b1;
      else cyc++;
    end
    check("dbg_latency", cyc, lat);
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int cyc;
    int first_ack, second_ack;
    logic got;
    for (int i = 0; i < 512; i++) ram[i] = 32'd0;
    ram[9'h010] = 32'hDEADBEEF;
    mem_rdata = '0;
    c0_mem_rdata = '0;
    reset = 1'b1;
    cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    c0_read = 0; c0_zero = 0; c0_addr = '0; c0_zdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    check("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_strobes", {28'd0, mem_en, mem_we, cpu_done, dbg_ack}, 32'd0);

    // 1: CPU read with one wait state
    expect_item(1'b0, 32'hDEADBEEF);
    cpu_txn(1'b1, 1'b0, 9'h010, 32'd0, 3);

    // 2: debug write, CPU reads it back; dbg_rdata stays 0
    expect_item(1'b1, 32'd0);
    dbg_txn(1'b1, 9'h1F0, 32'h12345678, 3);
    expect_item(1'b0, 32'h12345678);
    cpu_txn(1'b1, 1'b0, 9'h1F0, 32'd0, 3);

    // 4: read+write together is a write; cpu_rdata unchanged
    expect_item(1'b0, 32'h12345678);
    cpu_txn(1'b1, 1'b1, 9'h005, 32'hA5A5A5A5, 3);
    check("ram_005_written", ram[9'h005], 32'hA5A5A5A5);

    // 3: ties. After reset last owner is debug, so the first tie goes to CPU either way.
    do_reset();
    expect_item(1'b0, 32'hDEADBEEF);
    expect_item(1'b1, 32'hA5A5A5A5);
    fork
      cpu_txn(1'b1, 1'b0, 9'h010, 32'd0, 3);
      dbg_txn(1'b0, 9'h005, 32'd0, 7);
    join
    expect_item(1'b0, 32'h12345678);
    cpu_txn(1'b1, 1'b0, 9'h1F0, 32'd0, 3);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expect_item(1'b1, 32'hDEADBEEF);
    expect_item(1'b0, 32'hA5A5A5A5);
    fork
      cpu_txn(1'b1, 1'b0, 9'h005, 32'd0, 7);
      dbg_txn(1'b0, 9'h010, 32'd0, 3);
    join
`else
    expect_item(1'b0, 32'hA5A5A5A5);
    expect_item(1'b1, 32'hDEADBEEF);
    fork
      cpu_txn(1'b1, 1'b0, 9'h005, 32'd0, 3);
      dbg_txn(1'b0, 9'h010, 32'd0, 7);
    join
`endif

    // 5: reset during WAIT, request held, re-accepted with full latency
    expect_item(1'b0, 32'hDEADBEEF);
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_addr = 9'h010;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_wait_no_done", {31'd0, cpu_done}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_strobes", {28'd0, mem_en, mem_we, cpu_done, dbg_ack}, 32'd0);
    check("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mid_dbg_rdata", dbg_rdata, 32'd0);
    check("rst_mid_mem_addr", {23'd0, mem_addr}, 32'd0);
    cyc = 3;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      cyc++;
      if (cpu_done) got = 1'b1;
    end
    check("rst_reaccept_latency", cyc, 6);
    @(posedge clk); #1 cpu_read = 1'b0;

    // 6: zero wait states, CPU read held continuously
    @(posedge clk); #1;
    c0_read = 1'b1; c0_addr = 9'h033;
    first_ack = -1;
    second_ack = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) begin
        check("ws0_masked_idle_en", {31'd0, c0_mem_en}, 32'd0);
        check("ws0_rdata", c0_rdata, 32'hC0DE0033);
      end
      if (c0_done) begin
        if (first_ack < 0) first_ack = c;
        else if (second_ack < 0) second_ack = c;
      end
    end
    check("ws0_first_ack", first_ack, 2);
    check("ws0_second_ack", second_ack, 6);
    @(posedge clk); #1 c0_read = 1'b0;

    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
